// File: rtl/adc_pkg.sv
// Shared types and frame constants for the phase-wire ADC reader.
// The frame is 16 bits; the lead bits must read back as zero.
package adc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SHIFT = 2'd2,
        HOLD  = 2'd3
    } adc_state_t;

    localparam int ADC_FRAME_BITS     = 16;
    localparam int ADC_DATA_BITS      = 12;
    localparam int ADC_LEAD_BITS      = 4;
    localparam int ADC_ADDR_FIRST_BIT = 2;
    localparam int ADC_CHAN_BITS      = 3;

    // Index of the SCLK event that closes the frame (one past the 16th rise).
    localparam logic [4:0] ADC_EDGE_LAST = 5'd31;

    // DIN value for frame bit idx: the channel address is sent MSB first.
    function automatic logic frame_bit(input logic [ADC_CHAN_BITS-1:0] addr,
                                       input logic [3:0] idx);
        logic bit_v;
        case (idx)
            4'(ADC_ADDR_FIRST_BIT):     bit_v = addr[2];
            4'(ADC_ADDR_FIRST_BIT + 1): bit_v = addr[1];
            4'(ADC_ADDR_FIRST_BIT + 2): bit_v = addr[0];
            default:                    bit_v = 1'b0;
        endcase
        return bit_v;
    endfunction

    function automatic logic frame_error(input logic [ADC_FRAME_BITS-1:0] frame);
        return |frame[ADC_FRAME_BITS-1 -: ADC_LEAD_BITS];
    endfunction

endpackage

// File: rtl/adc_sclk_tick.sv
// Half-period tick generator: pulses once every CLK_DIV cycles while not cleared.
// Clearing holds the count at zero so the first tick lands CLK_DIV-1 cycles later.
module adc_sclk_tick #(
    parameter int CLK_DIV = 25
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CNT_W-1:0] cnt_r;
    logic             tick_s;

    assign tick_s = (cnt_r == CNT_W'(CLK_DIV - 1));
    assign tick   = tick_s;

    // Half-period counter, wraps on each tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (clear || tick_s) begin
            cnt_r <= {CNT_W{1'b0}};
        end else begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

endmodule

// File: rtl/phase_adc_reader.sv
// Continuous SPI reader for the 8-channel 12-bit phase-wire ADC.
// Results lag the addressed channel by one frame, so the first frame only primes.
module phase_adc_reader
    import adc_pkg::*;
#(
    parameter int CLK_DIV = 25
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic                     Enable,
    input  logic [ADC_CHAN_BITS-1:0] ChannelSelect,
    input  logic                     AdcMiso,
    output logic                     AdcCsN,
    output logic                     AdcSclk,
    output logic                     AdcMosi,
    output logic [ADC_DATA_BITS-1:0] PhaseWireVoltage,
    output logic [ADC_CHAN_BITS-1:0] SampleChannel,
    output logic                     SampleValid,
    output logic                     FrameError,
    output logic                     Busy
);

    adc_state_t state_r, state_s;
    logic       tick_s;
    logic       clear_s;

    logic                      csn_r, csn_s;
    logic                      sclk_r, sclk_s;
    logic                      mosi_r, mosi_s;
    logic                      busy_r, busy_s;
    logic                      primed_r, primed_s;
    logic [ADC_CHAN_BITS-1:0]  addr_r, addr_s;
    logic [ADC_CHAN_BITS-1:0]  prev_addr_r, prev_addr_s;
    logic [ADC_FRAME_BITS-1:0] shift_r, shift_s;
    logic [4:0]                edge_r, edge_s;
    logic [ADC_DATA_BITS-1:0]  data_r, data_s;
    logic [ADC_CHAN_BITS-1:0]  chan_r, chan_s;
    logic                      err_r, err_s;
    logic                      valid_r, valid_s;

    assign clear_s = (state_r == IDLE);

    adc_sclk_tick #(
        .CLK_DIV(CLK_DIV)
    ) u_tick (
        .clk  (Clock),
        .rst  (Reset),
        .clear(clear_s),
        .tick (tick_s)
    );

    // FSM state register.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state decode.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (Enable) state_s = SETUP;
                else        state_s = IDLE;
            end
            SETUP: begin
                if (tick_s) state_s = SHIFT;
                else        state_s = SETUP;
            end
            SHIFT: begin
                if (tick_s && (edge_r == ADC_EDGE_LAST)) state_s = HOLD;
                else                                     state_s = SHIFT;
            end
            HOLD: begin
                if (tick_s && Enable)  state_s = SETUP;
                else if (tick_s)       state_s = IDLE;
                else                   state_s = HOLD;
            end
            default: state_s = IDLE;
        endcase
    end

    // FSM output decode: next values for the pin, shift and result registers.
    always_comb begin
        csn_s       = csn_r;
        sclk_s      = sclk_r;
        mosi_s      = mosi_r;
        busy_s      = busy_r;
        primed_s    = primed_r;
        addr_s      = addr_r;
        prev_addr_s = prev_addr_r;
        shift_s     = shift_r;
        edge_s      = edge_r;
        data_s      = data_r;
        chan_s      = chan_r;
        err_s       = err_r;
        valid_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (Enable) begin
                    csn_s  = 1'b0;
                    busy_s = 1'b1;
                    addr_s = ChannelSelect;
                end else begin
                    busy_s = 1'b0;
                end
            end
            SETUP: begin
                if (tick_s) begin
                    sclk_s = 1'b0;
                    mosi_s = frame_bit(addr_r, 4'd0);
                    edge_s = 5'd0;
                end else begin
                    sclk_s = 1'b1;
                end
            end
            SHIFT: begin
                if (tick_s && (edge_r == ADC_EDGE_LAST)) begin
                    csn_s       = 1'b1;
                    prev_addr_s = addr_r;
                    if (primed_r) begin
                        data_s  = shift_r[ADC_DATA_BITS-1:0];
                        chan_s  = prev_addr_r;
                        err_s   = frame_error(shift_r);
                        valid_s = 1'b1;
                    end else begin
                        primed_s = 1'b1;
                    end
                end else if (tick_s && !edge_r[0]) begin
                    sclk_s  = 1'b1;
                    shift_s = {shift_r[ADC_FRAME_BITS-2:0], AdcMiso};
                    edge_s  = edge_r + 5'd1;
                end else if (tick_s) begin
                    sclk_s = 1'b0;
                    mosi_s = frame_bit(addr_r, edge_r[4:1] + 4'd1);
                    edge_s = edge_r + 5'd1;
                end else begin
                    edge_s = edge_r;
                end
            end
            HOLD: begin
                if (tick_s && Enable) begin
                    csn_s  = 1'b0;
                    busy_s = 1'b1;
                    addr_s = ChannelSelect;
                end else if (tick_s) begin
                    busy_s = 1'b0;
                end else begin
                    csn_s = 1'b1;
                end
            end
            default: begin
                csn_s  = 1'b1;
                sclk_s = 1'b1;
                busy_s = 1'b0;
            end
        endcase
    end

    // Pin, datapath and result registers.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            csn_r       <= 1'b1;
            sclk_r      <= 1'b1;
            mosi_r      <= 1'b0;
            busy_r      <= 1'b0;
            primed_r    <= 1'b0;
            addr_r      <= {ADC_CHAN_BITS{1'b0}};
            prev_addr_r <= {ADC_CHAN_BITS{1'b0}};
            shift_r     <= {ADC_FRAME_BITS{1'b0}};
            edge_r      <= 5'd0;
            data_r      <= {ADC_DATA_BITS{1'b0}};
            chan_r      <= {ADC_CHAN_BITS{1'b0}};
            err_r       <= 1'b0;
            valid_r     <= 1'b0;
        end else begin
            csn_r       <= csn_s;
            sclk_r      <= sclk_s;
            mosi_r      <= mosi_s;
            busy_r      <= busy_s;
            primed_r    <= primed_s;
            addr_r      <= addr_s;
            prev_addr_r <= prev_addr_s;
            shift_r     <= shift_s;
            edge_r      <= edge_s;
            data_r      <= data_s;
            chan_r      <= chan_s;
            err_r       <= err_s;
            valid_r     <= valid_s;
        end
    end

    assign AdcCsN           = csn_r;
    assign AdcSclk          = sclk_r;
    assign AdcMosi          = mosi_r;
    assign Busy             = busy_r;
    assign PhaseWireVoltage = data_r;
    assign SampleChannel    = chan_r;
    assign FrameError       = err_r;
    assign SampleValid      = valid_r;

endmodule

// File: tb/tb_phase_adc_reader.sv
// Directed bench for phase_adc_reader with a behavioural ADC on the SPI pins.
module tb_phase_adc_reader;

    localparam int H = 4;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        Enable = 1'b0;
    logic [2:0]  ChannelSelect = 3'd0;
    logic        AdcMiso = 1'b0;
    logic        AdcCsN, AdcSclk, AdcMosi, SampleValid, FrameError, Busy;
    logic [11:0] PhaseWireVoltage;
    logic [2:0]  SampleChannel;

    phase_adc_reader #(.CLK_DIV(H)) dut (
        .Clock           (Clock),
        .Reset           (Reset),
        .Enable          (Enable),
        .ChannelSelect   (ChannelSelect),
        .AdcMiso         (AdcMiso),
        .AdcCsN          (AdcCsN),
        .AdcSclk         (AdcSclk),
        .AdcMosi         (AdcMosi),
        .PhaseWireVoltage(PhaseWireVoltage),
        .SampleChannel   (SampleChannel),
        .SampleValid     (SampleValid),
        .FrameError      (FrameError),
        .Busy            (Busy)
    );

    always #5 Clock = ~Clock;

    int cyc = 0;
    always @(posedge Clock) cyc <= cyc + 1;

    // Event monitor, sampled on the falling system clock edge.
    logic        prev_csn = 1'b1, prev_busy = 1'b0;
    int          fall_count = 0, rise_count = 0, last_fall = 0, last_rise = 0;
    int          sv_count = 0, sv_cyc = 0, busy_fall_count = 0, busy_fall_cyc = 0;
    logic [11:0] sv_data = 12'h000;
    logic [2:0]  sv_chan = 3'd0;
    logic        sv_err = 1'b0;
    always @(negedge Clock) begin
        if (prev_csn === 1'b1 && AdcCsN === 1'b0) begin fall_count++; last_fall = cyc; end
        if (prev_csn === 1'b0 && AdcCsN === 1'b1) begin rise_count++; last_rise = cyc; end
        if (prev_busy === 1'b1 && Busy === 1'b0) begin busy_fall_count++; busy_fall_cyc = cyc; end
        if (SampleValid === 1'b1) begin
            sv_count++; sv_cyc = cyc;
            sv_data = PhaseWireVoltage; sv_chan = SampleChannel; sv_err = FrameError;
        end
        prev_csn  = AdcCsN;
        prev_busy = Busy;
    end

    // ADC model: DOUT shifts on SCLK fall, DIN address sampled on SCLK rise.
    int          mode = 0, rk = 0;
    logic [15:0] fixed_word = 16'h0000, cur_word = 16'h0000;
    logic [2:0]  dec = 3'd0, prev_chan = 3'd0;
    always @(negedge AdcCsN) begin
        rk = 0;
        if (mode == 0) cur_word = fixed_word;
        else           cur_word = {5'b00000, prev_chan, 8'h00};
    end
    always @(negedge AdcSclk) begin
        if (AdcCsN === 1'b0) begin
            AdcMiso  = cur_word[15];
            cur_word = {cur_word[14:0], 1'b0};
        end
    end
    always @(posedge AdcSclk) begin
        if (AdcCsN === 1'b0) begin
            case (rk)
                2: dec[2] = AdcMosi;
                3: dec[1] = AdcMosi;
                4: dec[0] = AdcMosi;
                default: ;
            endcase
            rk++;
        end
    end
    always @(posedge AdcCsN) prev_chan = dec;

    int passes = 0, total = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passes++;
        end else begin
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_fall(output int c);
        int   start;
        logic seen;
        start = fall_count;
        seen  = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(posedge Clock);
            if (fall_count != start) begin seen = 1'b1; break; end
        end
        check("cs_fall_seen", 32'(seen), 32'd1);
        c = last_fall;
    endtask

    task automatic wait_rise(output int c);
        int   start;
        logic seen;
        start = rise_count;
        seen  = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(posedge Clock);
            if (rise_count != start) begin seen = 1'b1; break; end
        end
        check("cs_rise_seen", 32'(seen), 32'd1);
        c = last_rise;
    endtask

    task automatic check_sample(input string tag, input int base, input int fall_cyc,
                                input logic [11:0] data, input logic [2:0] chan, input logic err);
        check({tag, "_count"}, 32'(sv_count - base), 32'd1);
        check({tag, "_cycle"}, 32'(sv_cyc - fall_cyc), 32'(33 * H));
        check({tag, "_data"}, 32'(sv_data), 32'(data));
        check({tag, "_chan"}, 32'(sv_chan), 32'(chan));
        check({tag, "_err"}, 32'(sv_err), 32'(err));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int f1, r1, f2, r2, f, r, base, bad, fc, seen;

        repeat (3) @(posedge Clock);
        @(negedge Clock);
        check("rst_csn", 32'(AdcCsN), 32'd1);
        check("rst_sclk", 32'(AdcSclk), 32'd1);
        check("rst_mosi", 32'(AdcMosi), 32'd0);
        check("rst_busy", 32'(Busy), 32'd0);
        check("rst_data", 32'(PhaseWireVoltage), 32'd0);
        check("rst_chan", 32'(SampleChannel), 32'd0);
        check("rst_valid", 32'(SampleValid), 32'd0);
        check("rst_err", 32'(FrameError), 32'd0);
        Reset = 1'b0;

        // Disabled: pins and results must stay quiet.
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge Clock);
            if (AdcCsN !== 1'b1 || AdcSclk !== 1'b1 || AdcMosi !== 1'b0 || Busy !== 1'b0 ||
                PhaseWireVoltage !== 12'h000 || SampleChannel !== 3'd0 ||
                SampleValid !== 1'b0 || FrameError !== 1'b0) bad++;
        end
        check("idle_quiet_cycles_bad", 32'(bad), 32'd0);

        // Priming frame then first result.
        mode = 0; fixed_word = 16'h0A5C; ChannelSelect = 3'd3;
        base = sv_count;
        Enable = 1'b1;
        wait_fall(f1);
        check("busy_in_frame", 32'(Busy), 32'd1);
        wait_rise(r1);
        check("cs_low_len", 32'(r1 - f1), 32'(33 * H));
        check("prime_no_valid", 32'(sv_count - base), 32'd0);
        check("mosi_addr_bits", 32'(dec), 32'h3);
        wait_fall(f2);
        check("frame_period", 32'(f2 - f1), 32'(34 * H));
        wait_rise(r2);
        check_sample("f2", base, f2, 12'hA5C, 3'd3, 1'b0);

        // Channel sequence 3,5,7 with echoed data.
        mode = 1; ChannelSelect = 3'd5;
        base = sv_count;
        wait_fall(f);
        ChannelSelect = 3'd7;
        wait_rise(r);
        check_sample("ch3", base, f, 12'h300, 3'd3, 1'b0);
        check("ch3_data_matches_chan", 32'(sv_data[10:8]), 32'(sv_chan));
        base = sv_count;
        wait_fall(f);
        check("mosi_addr_late_change", 32'(ChannelSelect), 32'h7);
        mode = 0; fixed_word = 16'h4123; ChannelSelect = 3'd2;
        wait_rise(r);
        check_sample("ch5", base, f, 12'h500, 3'd5, 1'b0);
        check("ch5_data_matches_chan", 32'(sv_data[10:8]), 32'(sv_chan));

        // Nonzero lead bit: error flagged, data still published.
        base = sv_count;
        wait_fall(f);
        wait_rise(r);
        check_sample("lead_err", base, f, 12'h123, 3'd7, 1'b1);

        // Enable dropped mid-frame.
        base = sv_count;
        wait_fall(f);
        while (cyc < f + 50) @(negedge Clock);
        Enable = 1'b0;
        wait_rise(r);
        check_sample("drop_en", base, f, 12'h123, 3'd2, 1'b1);
        fc = busy_fall_count;
        seen = 0;
        for (int i = 0; i < 400; i++) begin
            @(posedge Clock);
            if (busy_fall_count != fc) begin seen = 1; break; end
        end
        check("busy_fall_seen", 32'(seen), 32'd1);
        check("busy_fall_time", 32'(busy_fall_cyc - f), 32'(34 * H));
        fc = fall_count;
        repeat (100) @(negedge Clock);
        check("stays_idle_falls", 32'(fall_count - fc), 32'd0);
        check("stays_idle_csn", 32'(AdcCsN), 32'd1);
        check("stays_idle_valid_count", 32'(sv_count - base), 32'd1);

        // Reset mid-frame of a primed frame.
        ChannelSelect = 3'd1;
        base = sv_count;
        Enable = 1'b1;
        wait_fall(f);
        while (cyc < f + 70) @(negedge Clock);
        check("pre_reset_sclk_low", 32'(AdcSclk), 32'd0);
        Reset = 1'b1; Enable = 1'b0;
        @(negedge Clock);
        check("reset_csn", 32'(AdcCsN), 32'd1);
        check("reset_sclk", 32'(AdcSclk), 32'd1);
        check("reset_busy", 32'(Busy), 32'd0);
        Reset = 1'b0;
        repeat (20) @(negedge Clock);
        check("reset_no_valid", 32'(sv_count - base), 32'd0);
        mode = 1; ChannelSelect = 3'd6;
        Enable = 1'b1;
        wait_fall(f);
        wait_rise(r);
        check("reprime_no_valid", 32'(sv_count - base), 32'd0);
        wait_fall(f);
        Enable = 1'b0;
        wait_rise(r);
        check_sample("after_reset", base, f, 12'h600, 3'd6, 1'b0);
        repeat (2 * H + 4) @(negedge Clock);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
